// File: rtl/booth_mac_accumulator.sv
// Registered-input MAC that sums signed 32-bit multiplier products over a frame
// and returns the frame total through a valid/ready result port.
module booth_mac_accumulator #(
    parameter int ACC_W = 40,
    parameter int CNT_W = 8,
    parameter int SAT   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             prod_valid,
    output logic             prod_ready,
    input  logic [31:0]      prod_data,
    input  logic             prod_last,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [31:0]      res_data,
    output logic [ACC_W-1:0] res_acc,
    output logic [CNT_W-1:0] res_count,
    output logic             res_sat,
    output logic             res_ovf,
    output logic             res_forced
);

    // state  | meaning
    // ACCUM  | s1 term is added into acc every cycle it is valid
    // DONE   | frame result held on res_* until res_ready
    localparam logic [0:0] ST_ACCUM = 1'b0;
    localparam logic [0:0] ST_DONE  = 1'b1;

    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_LAST = {{(CNT_W-1){1'b1}}, 1'b0};

    logic [0:0]       state;
    logic             s1_valid;
    logic [31:0]      s1_data;
    logic             s1_last;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] count;
    logic             ovf_sticky;

    logic             s1_consume;
    logic             take;
    logic [ACC_W-1:0] term;
    logic [ACC_W-1:0] sum;
    logic             add_ovf;
    logic             frame_end;
    logic [ACC_W-32:0] acc_hi;
    logic             acc_fits;

    assign s1_consume = (state == ST_ACCUM) && s1_valid;
    assign prod_ready = !s1_valid || s1_consume;
    assign take       = prod_valid && prod_ready;

    assign term      = {{(ACC_W-32){s1_data[31]}}, s1_data};
    assign sum       = acc + term;
    assign add_ovf   = (acc[ACC_W-1] == term[ACC_W-1]) && (sum[ACC_W-1] != acc[ACC_W-1]);
    // count still holds the pre-increment value, so this term is number 2**CNT_W-1
    assign frame_end = s1_last || (count == CNT_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            state      <= ST_ACCUM;
            s1_valid   <= 1'b0;
            s1_data    <= '0;
            s1_last    <= 1'b0;
            acc        <= '0;
            count      <= '0;
            ovf_sticky <= 1'b0;
            res_valid  <= 1'b0;
            res_forced <= 1'b0;
        end else begin
            if (take) begin
                s1_valid <= 1'b1;
                s1_data  <= prod_data;
                s1_last  <= prod_last;
            end else if (s1_consume) begin
                s1_valid <= 1'b0;
            end

            case (state)
                ST_ACCUM: begin
                    if (s1_valid) begin
                        acc        <= sum;
                        count      <= count + CNT_ONE;
                        ovf_sticky <= ovf_sticky || add_ovf;
                        if (frame_end) begin
                            state      <= ST_DONE;
                            res_valid  <= 1'b1;
                            res_forced <= !s1_last;
                        end
                    end
                end
                default: begin
                    if (res_ready) begin
                        state      <= ST_ACCUM;
                        acc        <= '0;
                        count      <= '0;
                        ovf_sticky <= 1'b0;
                        res_valid  <= 1'b0;
                        res_forced <= 1'b0;
                    end
                end
            endcase
        end
    end

    // acc fits in 32 signed bits when bits [ACC_W-1:31] are all equal
    assign acc_hi   = acc[ACC_W-1:31];
    assign acc_fits = (acc_hi == '0) || (&acc_hi);

    always_comb begin
        res_data = acc[31:0];
        res_sat  = 1'b0;
        if ((SAT != 0) && !acc_fits) begin
            res_sat  = 1'b1;
            res_data = acc[ACC_W-1] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end
    end

    assign res_acc   = acc;
    assign res_count = count;
    assign res_ovf   = ovf_sticky;

endmodule

// File: tb/tb_booth_mac_accumulator.sv
// Directed plus randomized frames for booth_mac_accumulator, checked against
// an arithmetic frame-sum model; a SAT=0 twin checks the wrapped result.
module tb_booth_mac_accumulator;
    logic        clk = 1'b0;
    logic        rst_n, clear, prod_valid, prod_last, res_ready;
    logic [31:0] prod_data;
    logic        prod_ready, res_valid, res_sat, res_ovf, res_forced;
    logic [31:0] res_data;
    logic [39:0] res_acc;
    logic [7:0]  res_count;
    logic        w_prod_ready, w_res_valid, w_res_sat, w_res_ovf, w_res_forced;
    logic [31:0] w_res_data;
    logic [39:0] w_res_acc;
    logic [7:0]  w_res_count;

    int total = 0;
    int bad   = 0;

    logic [31:0] frame_q[$];
    logic [39:0] exp_acc;
    logic [31:0] exp_data, exp_wrap;
    logic [7:0]  exp_count;
    logic        exp_sat, exp_ovf;

    always #5 clk = ~clk;

    booth_mac_accumulator #(.ACC_W(40), .CNT_W(8), .SAT(1)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .prod_valid(prod_valid),
        .prod_ready(prod_ready), .prod_data(prod_data), .prod_last(prod_last),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_acc(res_acc), .res_count(res_count), .res_sat(res_sat),
        .res_ovf(res_ovf), .res_forced(res_forced));

    booth_mac_accumulator #(.ACC_W(40), .CNT_W(8), .SAT(0)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .clear(clear), .prod_valid(prod_valid),
        .prod_ready(w_prod_ready), .prod_data(prod_data), .prod_last(prod_last),
        .res_valid(w_res_valid), .res_ready(res_ready), .res_data(w_res_data),
        .res_acc(w_res_acc), .res_count(w_res_count), .res_sat(w_res_sat),
        .res_ovf(w_res_ovf), .res_forced(w_res_forced));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Frame sum computed in 64-bit arithmetic, folded back into 40 bits per term.
    task automatic model();
        longint run = 0;
        longint full;
        logic [39:0] w;
        exp_ovf = 1'b0;
        foreach (frame_q[i]) begin
            int v = int'(frame_q[i]);
            full = run + longint'(v);
            w    = full[39:0];
            run  = longint'($signed(w));
            if (run != full) exp_ovf = 1'b1;
        end
        exp_acc   = run[39:0];
        exp_count = 8'(frame_q.size());
        exp_wrap  = run[31:0];
        if (run > 64'sd2147483647) begin
            exp_data = 32'h7FFF_FFFF; exp_sat = 1'b1;
        end else if (run < -64'sd2147483648) begin
            exp_data = 32'h8000_0000; exp_sat = 1'b1;
        end else begin
            exp_data = run[31:0]; exp_sat = 1'b0;
        end
    endtask

    task automatic send_frame(input bit end_last);
        int n;
        foreach (frame_q[i]) begin
            @(negedge clk);
            prod_valid = 1'b1;
            prod_data  = frame_q[i];
            prod_last  = end_last && (i == frame_q.size() - 1);
            n = 0;
            while (!prod_ready && n < 100) begin
                @(negedge clk);
                n++;
            end
            if (n >= 100) chk("ready_timeout", 64'(prod_ready), 64'd1);
            @(posedge clk);
        end
    endtask

    // Called right after the edge that accepted the final term.
    task automatic finish_frame(input bit forced);
        @(negedge clk);
        prod_valid = 1'b0;
        prod_last  = 1'b0;
        chk("lat_early", 64'(res_valid), 64'd0);
        @(negedge clk);
        chk("lat_valid", 64'(res_valid), 64'd1);
        model();
        chk("res_data",   64'(res_data),   64'(exp_data));
        chk("res_acc",    64'(res_acc),    64'(exp_acc));
        chk("res_count",  64'(res_count),  64'(exp_count));
        chk("res_sat",    64'(res_sat),    64'(exp_sat));
        chk("res_ovf",    64'(res_ovf),    64'(exp_ovf));
        chk("res_forced", 64'(res_forced), 64'(forced));
        chk("wrap_data",  64'(w_res_data), 64'(exp_wrap));
        chk("wrap_sat",   64'(w_res_sat),  64'd0);
    endtask

    task automatic release_result(input int hold);
        for (int c = 0; c < hold; c++) begin
            @(posedge clk);
            @(negedge clk);
            chk("hold_valid", 64'(res_valid), 64'd1);
            chk("hold_data",  64'(res_data),  64'(exp_data));
        end
        res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        res_ready = 1'b0;
        chk("rel_valid", 64'(res_valid), 64'd0);
        chk("rel_count", 64'(res_count), 64'd0);
        chk("rel_acc",   64'(res_acc),   64'd0);
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_valid"}, 64'(res_valid),  64'd0);
        chk({tag, "_acc"},   64'(res_acc),    64'd0);
        chk({tag, "_count"}, 64'(res_count),  64'd0);
        chk({tag, "_data"},  64'(res_data),   64'd0);
        chk({tag, "_flags"}, {61'd0, res_sat, res_ovf, res_forced}, 64'd0);
        chk({tag, "_ready"}, 64'(prod_ready), 64'd1);
    endtask

    initial begin
        rst_n = 1'b0; clear = 1'b0; prod_valid = 1'b0; prod_last = 1'b0;
        prod_data = '0; res_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_idle("reset");
        rst_n = 1'b1;

        // basic three-term frame
        frame_q = '{32'd100, -32'sd30, 32'd7};
        send_frame(1'b1);
        finish_frame(1'b0);
        chk("t1_const", 64'(res_data), 64'd77);
        release_result(0);

        // positive saturation
        frame_q = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF};
        send_frame(1'b1);
        finish_frame(1'b0);
        chk("t2_acc_const", 64'(res_acc), 64'h01_7FFF_FFFD);
        chk("t2_wrap_const", 64'(w_res_data), 64'h7FFF_FFFD);
        release_result(1);

        // most-negative single term, then backpressure while result held
        frame_q = '{32'h8000_0000};
        send_frame(1'b1);
        finish_frame(1'b0);
        chk("t3_sat_const", 64'(res_sat), 64'd0);
        prod_valid = 1'b1; prod_data = 32'd11; prod_last = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            @(negedge clk);
            chk("bp_ready", 64'(prod_ready), 64'd0);
            chk("bp_data",  64'(res_data),   64'h8000_0000);
            chk("bp_count", 64'(res_count),  64'd1);
        end
        res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        res_ready = 1'b0;
        chk("bp_release_ready", 64'(prod_ready), 64'd1);
        prod_data = 32'd20; prod_last = 1'b1;
        @(posedge clk);
        frame_q = '{32'd11, 32'd20};
        finish_frame(1'b0);
        release_result(0);

        // frame closed by the term limit
        frame_q = {};
        for (int i = 0; i < 255; i++) frame_q.push_back(32'd1);
        send_frame(1'b0);
        finish_frame(1'b1);
        chk("t5_count_const", 64'(res_count), 64'd255);
        release_result(0);

        // reset mid-frame discards the partial sum
        frame_q = '{32'd40, 32'd50};
        send_frame(1'b0);
        @(negedge clk);
        prod_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_idle("midrst");
        rst_n = 1'b1;
        frame_q = '{32'd5};
        send_frame(1'b1);
        finish_frame(1'b0);
        release_result(0);

        // clear mid-frame, with a simultaneous handshake that must be dropped
        frame_q = '{32'd40, 32'd50};
        send_frame(1'b0);
        @(negedge clk);
        prod_valid = 1'b1; prod_data = 32'd9; prod_last = 1'b0;
        clear = 1'b1;
        @(posedge clk);
        @(negedge clk);
        clear = 1'b0;
        prod_valid = 1'b0;
        check_idle("clear");
        frame_q = '{32'd5};
        send_frame(1'b1);
        finish_frame(1'b0);
        chk("t6_count_const", 64'(res_count), 64'd1);
        release_result(0);

        // random frames
        for (int f = 0; f < 20; f++) begin
            int len = $urandom_range(1, 6);
            frame_q = {};
            for (int i = 0; i < len; i++) begin
                case ($urandom_range(0, 3))
                    0: frame_q.push_back(32'h7FFF_FFFF);
                    1: frame_q.push_back(32'h8000_0000);
                    2: frame_q.push_back(32'($urandom_range(0, 2000)) - 32'd1000);
                    default: frame_q.push_back($urandom);
                endcase
            end
            send_frame(1'b1);
            finish_frame(1'b0);
            release_result($urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
